// File: rtl/regfile_pkg.sv
// Shared defaults, typedefs and constants for the multi-ported scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int TAGW_DEF  = 4;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
  typedef logic [TAGW_DEF-1:0] reg_tag_t;

  // Architectural zero register: never written, never busy.
  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/regfile_if.sv
// Read, writeback and issue bundle of the register file; master drives requests, slave is the file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRPORT = 2,
  parameter int NWPORT = 2,
  parameter int TAGW   = TAGW_DEF
);

  localparam int AW = $clog2(NREGS);

  logic [NRPORT-1:0][AW-1:0]   rd_addr;
  logic [NRPORT-1:0][XLEN-1:0] rd_data;
  logic [NRPORT-1:0]           rd_ready;

  logic [NWPORT-1:0]           wr_en;
  logic [NWPORT-1:0][AW-1:0]   wr_addr;
  logic [NWPORT-1:0][XLEN-1:0] wr_data;
  logic [NWPORT-1:0][TAGW-1:0] wr_tag;

  logic                        iss_en;
  logic [AW-1:0]               iss_addr;
  logic [TAGW-1:0]             iss_tag;

  logic [NWPORT-1:0]           wr_drop;
  logic                        err_wconflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_tag, iss_en, iss_addr, iss_tag,
    input  rd_data, rd_ready, wr_drop, err_wconflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_tag, iss_en, iss_addr, iss_tag,
    output rd_data, rd_ready, wr_drop, err_wconflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy/tag tracking per register, writeback commit qualification, stale-drop and conflict pulses.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NWPORT = 2,
  parameter int TAGW   = TAGW_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NWPORT-1:0]                    wr_en,
  input  logic [NWPORT-1:0][$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWPORT-1:0][TAGW-1:0]          wr_tag,
  input  logic                                 iss_en,
  input  logic [$clog2(NREGS)-1:0]             iss_addr,
  input  logic [TAGW-1:0]                      iss_tag,
  output logic [NWPORT-1:0]                    commit,
  output logic [NREGS-1:0]                     busy,
  output logic [NWPORT-1:0]                    wr_drop,
  output logic                                 err_wconflict
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [TAGW-1:0]   tag_q [NREGS];
  logic [TAGW-1:0]   tag_d [NREGS];
  logic [NWPORT-1:0] drop_p0;
  logic [NWPORT-1:0] drop_p1;
  logic              conflict_p0;
  logic              conflict_p1;
  logic              iss_live;

  assign iss_live = iss_en && (iss_addr != AW'(X0));

  // A write commits only if it targets the outstanding producer tag; anything else is stale.
  always_comb begin
    commit  = '0;
    drop_p0 = '0;
    for (int p = 0; p < NWPORT; p++) begin
      if (wr_en[p] && (wr_addr[p] != AW'(X0))) begin
        if (busy_q[wr_addr[p]] && (tag_q[wr_addr[p]] == wr_tag[p])) begin
          commit[p] = 1'b1;
        end else begin
          drop_p0[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    conflict_p0 = 1'b0;
    for (int p = 0; p < NWPORT; p++) begin
      for (int q = 0; q < NWPORT; q++) begin
        if ((q > p) && commit[p] && commit[q] && (wr_addr[p] == wr_addr[q])) begin
          conflict_p0 = 1'b1;
        end
      end
    end
  end

  // Issue is applied after commits so a same-cycle issue keeps the register busy with its new tag.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int p = 0; p < NWPORT; p++) begin
      if (commit[p]) begin
        busy_d[wr_addr[p]] = 1'b0;
      end
    end
    if (iss_live) begin
      busy_d[iss_addr] = 1'b1;
      tag_d[iss_addr]  = iss_tag;
    end
  end

  // ---- stage p0 -> p1: state and event pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      drop_p1     <= '0;
      conflict_p1 <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      drop_p1     <= drop_p0;
      conflict_p1 <= conflict_p0;
      for (int r = 0; r < NREGS; r++) begin
        tag_q[r] <= tag_d[r];
      end
    end
  end

  assign busy          = busy_q;
  assign wr_drop       = drop_p1;
  assign err_wconflict = conflict_p1;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register producer-tag scoreboard and x0 hardwired to zero.
// Build option: define REGFILE_BYPASS_EN to forward committing writeback data to same-cycle reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRPORT = 2,
  parameter int NWPORT = 2,
  parameter int TAGW   = TAGW_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [NWPORT-1:0] commit;
  logic [NREGS-1:0]  busy;
  logic [XLEN-1:0]   data_q [NREGS];
  logic [XLEN-1:0]   data_d [NREGS];

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWPORT (NWPORT),
    .TAGW   (TAGW)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (bus.wr_en),
    .wr_addr       (bus.wr_addr),
    .wr_tag        (bus.wr_tag),
    .iss_en        (bus.iss_en),
    .iss_addr      (bus.iss_addr),
    .iss_tag       (bus.iss_tag),
    .commit        (commit),
    .busy          (busy),
    .wr_drop       (bus.wr_drop),
    .err_wconflict (bus.err_wconflict)
  );

  // Ascending port order makes the highest committing port win on an address clash.
  always_comb begin
    data_d = data_q;
    for (int p = 0; p < NWPORT; p++) begin
      if (commit[p]) begin
        data_d[bus.wr_addr[p]] = bus.wr_data[p];
      end
    end
  end

  // ---- stage p0 -> p1: register storage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= data_d[r];
      end
    end
  end

  // x0 storage is never written and never busy, so it reads as zero/ready without a special case.
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '0;
    for (int r = 0; r < NRPORT; r++) begin
      bus.rd_data[r]  = data_q[bus.rd_addr[r]];
      bus.rd_ready[r] = !busy[bus.rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWPORT; p++) begin
        if (commit[p] && (bus.wr_addr[p] == bus.rd_addr[r])) begin
          bus.rd_data[r]  = bus.wr_data[p];
          bus.rd_ready[r] = 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: commit, stale drop, conflict, issue/wb race, x0, bypass, reset.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_if #(.XLEN(32), .NREGS(32), .NRPORT(2), .NWPORT(2), .TAGW(4)) bus ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRPORT(2), .NWPORT(2), .TAGW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_tag   = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.iss_tag  = '0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [3:0] t);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
    bus.iss_tag  = t;
  endtask

  task automatic wb(input int p, input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = a;
    bus.wr_tag[p]  = t;
    bus.wr_data[p] = d;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd0;
    rst_n = 1'b0;
    #2;
    checks++; if (bus.rd_data[0] !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", bus.rd_data[0], 32'h0); end
    checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want %b", bus.rd_ready, 2'b11); end
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL reset_drop got %b want %b", bus.wr_drop, 2'b00); end
    checks++; if (bus.err_wconflict !== 1'b0) begin errors++; $display("FAIL reset_err got %b want %b", bus.err_wconflict, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_commit();
    @(negedge clk); idle(); issue(5'd5, 4'd3);
    post_edge();
    @(negedge clk); idle(); wb(0, 5'd5, 4'd3, 32'hDEADBEEF); bus.rd_addr[0] = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (bus.rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_byp_data got %h want %h", bus.rd_data[0], 32'hDEADBEEF); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL commit_byp_ready got %b want %b", bus.rd_ready[0], 1'b1); end
`else
    checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL commit_busy got %b want %b", bus.rd_ready[0], 1'b0); end
`endif
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL commit_drop got %b want %b", bus.wr_drop, 2'b00); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_data got %h want %h", bus.rd_data[0], 32'hDEADBEEF); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL commit_ready got %b want %b", bus.rd_ready[0], 1'b1); end
  endtask

  task automatic test_stale();
    @(negedge clk); idle(); issue(5'd5, 4'd3);
    post_edge();
    @(negedge clk); idle(); issue(5'd5, 4'd7);
    post_edge();
    @(negedge clk); idle(); wb(0, 5'd5, 4'd3, 32'h12345678); bus.rd_addr[0] = 5'd5;
    #1;
    checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL stale_pre_ready got %b want %b", bus.rd_ready[0], 1'b0); end
    checks++; if (bus.rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stale_pre_data got %h want %h", bus.rd_data[0], 32'hDEADBEEF); end
    post_edge();
    checks++; if (bus.wr_drop !== 2'b01) begin errors++; $display("FAIL stale_drop got %b want %b", bus.wr_drop, 2'b01); end
    @(negedge clk); idle();
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL stale_drop_clear got %b want %b", bus.wr_drop, 2'b00); end
    checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL stale_busy got %b want %b", bus.rd_ready[0], 1'b0); end
    checks++; if (bus.rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stale_data got %h want %h", bus.rd_data[0], 32'hDEADBEEF); end
    @(negedge clk); idle(); wb(1, 5'd5, 4'd7, 32'hCAFE0007);
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL stale_tag7_drop got %b want %b", bus.wr_drop, 2'b00); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.rd_data[0] !== 32'hCAFE0007) begin errors++; $display("FAIL stale_tag7_data got %h want %h", bus.rd_data[0], 32'hCAFE0007); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL stale_tag7_ready got %b want %b", bus.rd_ready[0], 1'b1); end
  endtask

  task automatic test_conflict();
    @(negedge clk); idle(); issue(5'd9, 4'd2);
    post_edge();
    checks++; if (bus.err_wconflict !== 1'b0) begin errors++; $display("FAIL conflict_idle got %b want %b", bus.err_wconflict, 1'b0); end
    @(negedge clk); idle(); wb(0, 5'd9, 4'd2, 32'h11); wb(1, 5'd9, 4'd2, 32'h22);
    post_edge();
    checks++; if (bus.err_wconflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse got %b want %b", bus.err_wconflict, 1'b1); end
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL conflict_drop got %b want %b", bus.wr_drop, 2'b00); end
    @(negedge clk); idle(); bus.rd_addr[0] = 5'd9; #1;
    checks++; if (bus.rd_data[0] !== 32'h22) begin errors++; $display("FAIL conflict_data got %h want %h", bus.rd_data[0], 32'h22); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL conflict_ready got %b want %b", bus.rd_ready[0], 1'b1); end
    post_edge();
    checks++; if (bus.err_wconflict !== 1'b0) begin errors++; $display("FAIL conflict_once got %b want %b", bus.err_wconflict, 1'b0); end
  endtask

  task automatic test_issue_wb();
    @(negedge clk); idle(); issue(5'd4, 4'd1);
    post_edge();
    @(negedge clk); idle(); wb(0, 5'd4, 4'd1, 32'hA5A5A5A5); issue(5'd4, 4'd6);
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL race_drop got %b want %b", bus.wr_drop, 2'b00); end
    @(negedge clk); idle(); bus.rd_addr[0] = 5'd4; #1;
    checks++; if (bus.rd_data[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL race_data got %h want %h", bus.rd_data[0], 32'hA5A5A5A5); end
    checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL race_busy got %b want %b", bus.rd_ready[0], 1'b0); end
    @(negedge clk); idle(); wb(1, 5'd4, 4'd6, 32'h0000000B);
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL race_newtag_drop got %b want %b", bus.wr_drop, 2'b00); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.rd_data[0] !== 32'h0000000B) begin errors++; $display("FAIL race_newtag_data got %h want %h", bus.rd_data[0], 32'h0000000B); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL race_newtag_ready got %b want %b", bus.rd_ready[0], 1'b1); end
  endtask

  task automatic test_x0();
    @(negedge clk); idle();
    issue(5'd0, 4'd1); wb(0, 5'd0, 4'd0, 32'hFFFF); wb(1, 5'd0, 4'd1, 32'hFFFF);
    bus.rd_addr[0] = 5'd0; bus.rd_addr[1] = 5'd0; #1;
    checks++; if (bus.rd_data[1] !== 32'h0) begin errors++; $display("FAIL x0_same_data got %h want %h", bus.rd_data[1], 32'h0); end
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL x0_drop got %b want %b", bus.wr_drop, 2'b00); end
    checks++; if (bus.err_wconflict !== 1'b0) begin errors++; $display("FAIL x0_err got %b want %b", bus.err_wconflict, 1'b0); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.rd_data[0] !== 32'h0) begin errors++; $display("FAIL x0_data got %h want %h", bus.rd_data[0], 32'h0); end
    checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL x0_ready got %b want %b", bus.rd_ready, 2'b11); end
  endtask

  task automatic test_bypass();
    @(negedge clk); idle(); issue(5'd6, 4'd5);
    post_edge();
    @(negedge clk); idle(); wb(0, 5'd6, 4'd5, 32'h55); bus.rd_addr[1] = 5'd6; #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (bus.rd_data[1] !== 32'h55) begin errors++; $display("FAIL bypass_data got %h want %h", bus.rd_data[1], 32'h55); end
    checks++; if (bus.rd_ready[1] !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b want %b", bus.rd_ready[1], 1'b1); end
`else
    checks++; if (bus.rd_data[1] !== 32'h0) begin errors++; $display("FAIL nobypass_data got %h want %h", bus.rd_data[1], 32'h0); end
    checks++; if (bus.rd_ready[1] !== 1'b0) begin errors++; $display("FAIL nobypass_ready got %b want %b", bus.rd_ready[1], 1'b0); end
`endif
    post_edge();
    @(negedge clk); idle(); #1;
    checks++; if (bus.rd_data[1] !== 32'h55) begin errors++; $display("FAIL bypass_next_data got %h want %h", bus.rd_data[1], 32'h55); end
    checks++; if (bus.rd_ready[1] !== 1'b1) begin errors++; $display("FAIL bypass_next_ready got %b want %b", bus.rd_ready[1], 1'b1); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle();
    issue(5'd7, 4'd1); wb(0, 5'd9, 4'd3, 32'h77); wb(1, 5'd5, 4'd9, 32'h88);
    bus.rd_addr[0] = 5'd9; bus.rd_addr[1] = 5'd4;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rd_data !== {32'h0, 32'h0}) begin errors++; $display("FAIL rstmid_data got %h want %h", bus.rd_data, 64'h0); end
    checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL rstmid_ready got %b want %b", bus.rd_ready, 2'b11); end
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL rstmid_drop got %b want %b", bus.wr_drop, 2'b00); end
    bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd6; #1;
    checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL rstmid_ready2 got %b want %b", bus.rd_ready, 2'b11); end
    checks++; if (bus.rd_data[1] !== 32'h0) begin errors++; $display("FAIL rstmid_x6 got %h want %h", bus.rd_data[1], 32'h0); end
    @(negedge clk); idle(); rst_n = 1'b1; issue(5'd3, 4'd2);
    bus.rd_addr[0] = 5'd3; bus.rd_addr[1] = 5'd7;
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL rstrel_drop got %b want %b", bus.wr_drop, 2'b00); end
    checks++; if (bus.err_wconflict !== 1'b0) begin errors++; $display("FAIL rstrel_err got %b want %b", bus.err_wconflict, 1'b0); end
    checks++; if (bus.rd_ready !== 2'b10) begin errors++; $display("FAIL rstrel_first_issue got %b want %b", bus.rd_ready, 2'b10); end
    @(negedge clk); idle();
    post_edge();
    checks++; if (bus.wr_drop !== 2'b00) begin errors++; $display("FAIL rstrel_drop2 got %b want %b", bus.wr_drop, 2'b00); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.rd_addr = '0;
    test_reset();
    test_commit();
    test_stale();
    test_conflict();
    test_issue_wb();
    test_x0();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width.
REQ-002 SHALL have parameter NREGS, default 32: architectural registers; x0 is hardwired zero.
REQ-003 SHALL have parameter NRPORT, default 2: read ports.
REQ-004 SHALL have parameter NWPORT, default 2: writeback ports.
REQ-005 SHALL have parameter TAGW, default 4: producer tag width; AW = $clog2(NREGS).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have ports rd_addr[NRPORT], input, AW: read addresses.
REQ-009 SHALL have ports rd_data[NRPORT] (output, XLEN) and rd_ready[NRPORT] (output, 1): read value and not-busy flag.
REQ-010 SHALL have ports wr_en[NWPORT] (input, 1), wr_addr[NWPORT] (input, AW), wr_data[NWPORT] (input, XLEN) and wr_tag[NWPORT] (input, TAGW): writeback.
REQ-011 SHALL have ports iss_en (input, 1), iss_addr (input, AW) and iss_tag (input, TAGW): issue, which marks the destination busy.
REQ-012 SHALL have ports wr_drop[NWPORT] (output, 1, registered pulse: stale write dropped) and err_wconflict (output, 1, registered pulse: same-address committing writes).

Function
REQ-013 SHALL hold, per register, data[XLEN], busy and tag[TAGW].
REQ-014 SHALL mark writeback port p as committing when wr_en[p] is high, wr_addr[p] is not 0, busy[a] is high and tag[a] equals wr_tag[p].
REQ-015 SHALL, on each clk edge for a committing port, write wr_data into data[a] and clear busy[a]; a non-committing wr_en write to a non-zero address is dropped and pulses wr_drop[p] the next cycle.
REQ-016 SHALL, when several ports commit to the same address, let the highest port index win and pulse err_wconflict for one cycle on the next cycle.
REQ-017 SHALL, when iss_en is high and iss_addr is not 0, set busy[iss_addr] = 1 and tag[iss_addr] = iss_tag on the clk edge.
REQ-018 SHALL, on same-cycle issue and committing writeback to one register, write the data and let the issue win: busy stays 1 with the new tag.
REQ-019 SHALL ignore writes and issues to x0; x0 is never dropped, never busy and never flagged.
REQ-020 SHALL make reads combinational with zero latency: rd_data = data[rd_addr] and rd_ready = !busy[rd_addr].
REQ-021 SHALL return 0 with rd_ready = 1 for a read of x0.
REQ-022 SHALL make rd_ready reflect pre-edge state; a same-cycle issue is not seen by reads until the next cycle.
REQ-023 SHALL hold wr_drop and err_wconflict low in any cycle without a triggering event.

Reset
REQ-024 SHALL, while rst_n is low, clear all data, busy and tag entries and drive wr_drop and err_wconflict to 0, asynchronously.
REQ-025 SHALL, on reset asserted mid-operation, discard pending writes and issues, with no pulse after release.
REQ-026 SHALL accept the first write or issue on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro REGFILE_BYPASS_EN is defined, bypass reads: a read whose address matches a committing write that cycle returns that wr_data (highest committing port) with rd_ready = 1.
REQ-028 SHALL, when REGFILE_BYPASS_EN is undefined, show written data on reads only from the cycle after the write edge.

Structure
REQ-029 SHALL place XLEN, NREGS, TAGW defaults, the reg_addr_t / reg_data_t / reg_tag_t typedefs and the x0 constant in package regfile_pkg.
REQ-030 SHALL implement busy/tag tracking, commit qualification and conflict detection in sub-module regfile_scoreboard; data storage and read muxing stay in regfile_mp.

Verification
REQ-031 SHALL cover: issue x5 tag 3, next cycle wb port0 x5 tag 3 data 0xDEADBEEF -> x5 reads 0xDEADBEEF, ready = 1, wr_drop = 0.
REQ-032 SHALL cover: issue x5 tag 3, then issue x5 tag 7, then wb x5 tag 3 -> wr_drop[0] pulses 1 cycle, x5 stays busy, data unchanged.
REQ-033 SHALL cover: ports 0 and 1 commit x9 tag 2 with 0x11 and 0x22 -> x9 = 0x22, err_wconflict pulses once.
REQ-034 SHALL cover: wb and issue x4 same cycle -> x4 data updated, busy = 1 with new tag; writes/issue to x0 with 0xFFFF -> reads 0, ready = 1.
REQ-035 SHALL cover, with REGFILE_BYPASS_EN: committing wb x6 = 0x55 while reading x6 -> rd_data = 0x55 and ready = 1 in that same cycle; without the macro -> old value that cycle, 0x55 the next.
REQ-036 SHALL cover: reset asserted mid-stream -> all reads 0, all ready = 1, no pulses after release.
